pc_branch_unit: RTL and testbench
=================================

# pc_branch_unit

Program-counter register and branch-resolution stage of the RV32I single-cycle core. It sits directly downstream of the ALU and consumes the ALU comparison flags (`zero`, `blt`, `bge`, `bltu`, `bgeu`) and the ALU sum, which serves as the JALR target. From these it resolves B-type, JAL and JALR control flow and registers the next PC. A misaligned jump or branch target raises a trap: the unit holds the PC until the trap is acknowledged, then redirects to a fixed trap vector.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0100, PC value loaded on trap acknowledge.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `stall`  in  1  freezes PC and trap detection while in RUN.
- `branch`  in  1  current instruction is B-type.
- `jal`  in  1  current instruction is JAL.
- `jalr`  in  1  current instruction is JALR.
- `funct3`  in  3  B-type condition code.
- `imm`  in  32  sign-extended B/J immediate.
- `alu_result`  in  32  rs1+imm from the ALU (JALR target).
- `zero`, `blt`, `bge`, `bltu`, `bgeu`  in  1 each  ALU comparison flags.
- `trap_ack`  in  1  acknowledges a pending misaligned trap.
- `pc`  out  32  registered current PC.
- `pc_plus4`  out  32  pc+4 (combinational), the link value for JAL/JALR.
- `taken`  out  1  combinational; the current instruction redirects the PC.
- `misaligned`  out  1  registered; trap pending (state TRAP).
- `trap_pc`  out  32  registered PC of the faulting instruction.

## Operation
- FSM with two states: RUN and TRAP.
- Reset (`rst_n`=0 at an edge): `pc`=RESET_VECTOR, state=RUN, `misaligned`=0, `trap_pc`=0.
- Branch condition by `funct3`:
  - 000 BEQ: `zero`.
  - 001 BNE: !`zero`.
  - 100 BLT: `blt`.
  - 101 BGE: `bge`.
  - 110 BLTU: `bltu`.
  - 111 BGEU: `bgeu`.
  - 010 and 011: never taken.
- Priority when several are set: `jalr` > `jal` > `branch`.
- Target selection:
  - JALR: {`alu_result`[31:1],1'b0}.
  - JAL or taken branch: `pc`+`imm`.
  - Otherwise: `pc`+4.
  - All adds wrap modulo 2^32, with no carry out.
- `taken` = state RUN & ((`jalr` | `jal`) | (`branch` & condition)). It is 0 in TRAP.
- RUN, `stall`=1: `pc`, state and `trap_pc` hold; `taken` is still driven combinationally.
- RUN, `stall`=0:
  - If `taken` and target[1:0]≠0: state→TRAP, `trap_pc`←`pc`, `pc` holds.
  - Otherwise: `pc`←target.
- TRAP:
  - `pc` holds; `stall` is ignored.
  - `trap_ack`=1: `pc`←TRAP_VECTOR, state→RUN.
- `trap_ack` is ignored in RUN.
- A not-taken branch is never checked for alignment.
- `misaligned`=1 exactly when state=TRAP.
- `pc_plus4`=`pc`+4 in all states; 0xFFFF_FFFC+4 = 0x0000_0000.

## Timing
- Instruction at `pc` during cycle n; the resolved next PC is visible in cycle n+1, i.e. zero-bubble redirect.
- `taken` has zero latency from its inputs.
- Misaligned target detected at edge n: `misaligned`=1 and `trap_pc` valid from cycle n+1.
- `trap_ack` sampled at edge m≥n+1: `pc`=TRAP_VECTOR and `misaligned`=0 from cycle m+1. An ack in the first TRAP cycle is accepted.
- Reset overrides everything, including `stall` and a pending trap, at the same edge. Outputs reach reset values in the following cycle.
- `rst_n` low for multiple cycles: `pc` stays at RESET_VECTOR.

## Test plan
- Reset, then `rst_n`=1 with no control inputs for 3 cycles → `pc` sequence 0x0, 0x4, 0x8, 0xC; `taken`=0 throughout.
- `pc`=0x40, `branch`=1, `funct3`=001, `zero`=0, `imm`=-8 → `taken`=1, next `pc`=0x38. Same stimulus with `zero`=1 → next `pc`=0x44. `funct3`=010 with all flags 1 → next `pc`=0x44.
- `pc`=0x80, `jalr`=1, `jal`=1, `alu_result`=0x1235 → next `pc`=0x1234 (JALR wins, bit 0 cleared); `pc_plus4`=0x84 in the instruction cycle.
- `pc`=0x20, `jal`=1, `imm`=0x6 → `misaligned`=1, `trap_pc`=0x20, `pc`=0x20 held for 3 cycles with `stall` toggling. `trap_ack`=1 → `pc`=0x100, `misaligned`=0 the next cycle.
- `stall`=1 for 2 cycles with `branch`/`bge`=1 → `pc` unchanged, `taken`=1. Release `stall` → `pc`=`pc`+`imm`.
- `pc`=0xFFFF_FFFC, no control → next `pc`=0x0. `rst_n`=0 while in TRAP → `pc`=RESET_VECTOR, `misaligned`=0 next cycle.

Source files
------------

// File: rtl/pc_branch_unit_if.sv
// pc_branch_unit_if: control inputs and PC/trap outputs of the PC and branch-resolution stage.
interface pc_branch_unit_if;
  logic stall;
  logic branch;
  logic jal;
  logic jalr;
  logic [2:0] funct3;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic zero;
  logic blt;
  logic bge;
  logic bltu;
  logic bgeu;
  logic trap_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic taken;
  logic misaligned;
  logic [31:0] trap_pc;
  modport master (
    output stall, branch, jal, jalr, funct3, imm, alu_result,
    output zero, blt, bge, bltu, bgeu, trap_ack,
    input pc, pc_plus4, taken, misaligned, trap_pc
  );
  modport slave (
    input stall, branch, jal, jalr, funct3, imm, alu_result,
    input zero, blt, bge, bltu, bgeu, trap_ack,
    output pc, pc_plus4, taken, misaligned, trap_pc
  );
endinterface

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC register with B-type/JAL/JALR resolution and misaligned-target trap.
module pc_branch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input logic clk,
  input logic rst_n,
  pc_branch_unit_if.slave bus
);
  typedef enum logic {RUN, TRAP} state_t;
  state_t state;
  logic [31:0] pc_r;
  logic [31:0] trap_pc_r;
  logic misaligned_r;
  logic cond;
  logic taken;
  logic [31:0] target;
  always_comb begin
    cond = bus.funct3 == 3'b000 ? bus.zero :
           bus.funct3 == 3'b001 ? !bus.zero :
           bus.funct3 == 3'b100 ? bus.blt :
           bus.funct3 == 3'b101 ? bus.bge :
           bus.funct3 == 3'b110 ? bus.bltu :
           bus.funct3 == 3'b111 ? bus.bgeu : 1'b0;
    target = bus.jalr ? {bus.alu_result[31:1], 1'b0} :
             (bus.jal | (bus.branch & cond)) ? pc_r + bus.imm : pc_r + 32'd4;
    taken = (state == RUN) & (bus.jalr | bus.jal | (bus.branch & cond));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pc_r <= RESET_VECTOR;
      trap_pc_r <= '0;
      misaligned_r <= 1'b0;
    end else if (state == RUN) begin
      if (!bus.stall) begin
        if (taken && target[1:0] != 2'b00) begin
          state <= TRAP;
          trap_pc_r <= pc_r;
          misaligned_r <= 1'b1;
        end else begin
          pc_r <= target;
        end
      end
    end else if (bus.trap_ack) begin
      state <= RUN;
      pc_r <= TRAP_VECTOR;
      misaligned_r <= 1'b0;
    end
  end
  assign bus.pc = pc_r;
  assign bus.pc_plus4 = pc_r + 32'd4;
  assign bus.taken = taken;
  assign bus.misaligned = misaligned_r;
  assign bus.trap_pc = trap_pc_r;
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: table-driven vectors plus directed trap, stall and reset sequences.
module tb_pc_branch_unit;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  pc_branch_unit_if bus();
  pc_branch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] setpc;
    logic br;
    logic jal;
    logic jalr;
    logic [2:0] f3;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [4:0] flags;
    logic exp_taken;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t v[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.stall = 0; bus.branch = 0; bus.jal = 0; bus.jalr = 0; bus.funct3 = 3'b010;
    bus.imm = 0; bus.alu_result = 0; bus.trap_ack = 0;
    {bus.zero, bus.blt, bus.bge, bus.bltu, bus.bgeu} = 5'b0;
  endtask
  task automatic setpc(input logic [31:0] a);
    idle();
    bus.jalr = 1; bus.alu_result = a;
    step();
    idle();
    chk("setpc", bus.pc, a);
  endtask
  initial begin
    v[0]  = '{32'h40, 1, 0, 0, 3'b001, 32'hFFFF_FFF8, 0, 5'b00000, 1, 32'h38};
    v[1]  = '{32'h40, 1, 0, 0, 3'b001, 32'hFFFF_FFF8, 0, 5'b10000, 0, 32'h44};
    v[2]  = '{32'h40, 1, 0, 0, 3'b010, 32'hFFFF_FFF8, 0, 5'b11111, 0, 32'h44};
    v[3]  = '{32'h40, 1, 0, 0, 3'b011, 32'h10, 0, 5'b11111, 0, 32'h44};
    v[4]  = '{32'h200, 1, 0, 0, 3'b000, 32'h10, 0, 5'b10000, 1, 32'h210};
    v[5]  = '{32'h40, 1, 0, 0, 3'b100, 32'h100, 0, 5'b01000, 1, 32'h140};
    v[6]  = '{32'h40, 1, 0, 0, 3'b100, 32'h100, 0, 5'b10111, 0, 32'h44};
    v[7]  = '{32'h40, 1, 0, 0, 3'b111, 32'hFFFF_FFC0, 0, 5'b00001, 1, 32'h0};
    v[8]  = '{32'h1000, 1, 0, 0, 3'b110, 32'h4, 0, 5'b00010, 1, 32'h1004};
    v[9]  = '{32'h80, 0, 1, 1, 3'b000, 32'h40, 32'h1235, 5'b00000, 1, 32'h1234};
    v[10] = '{32'h80, 1, 1, 0, 3'b000, 32'h20, 0, 5'b00000, 1, 32'hA0};
    v[11] = '{32'hFFFF_FFFC, 0, 0, 0, 3'b000, 32'h8, 0, 5'b10000, 0, 32'h0};
    v[12] = '{32'h0, 0, 1, 0, 3'b000, 32'hFFFF_FFFC, 0, 5'b00000, 1, 32'hFFFF_FFFC};
    v[13] = '{32'h300, 1, 0, 0, 3'b101, 32'h8, 0, 5'b00100, 1, 32'h308};
    idle();
    rst_n = 0;
    step(); step();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_mis", {31'b0, bus.misaligned}, 32'h0);
    chk("rst_trap_pc", bus.trap_pc, 32'h0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", bus.pc, 32'(i * 4));
      chk("seq_taken", {31'b0, bus.taken}, 32'h0);
      if (i < 3) step();
    end
    for (int i = 0; i < 14; i++) begin
      setpc(v[i].setpc);
      bus.branch = v[i].br; bus.jal = v[i].jal; bus.jalr = v[i].jalr; bus.funct3 = v[i].f3;
      bus.imm = v[i].imm; bus.alu_result = v[i].alu;
      {bus.zero, bus.blt, bus.bge, bus.bltu, bus.bgeu} = v[i].flags;
      #1;
      chk($sformatf("v%0d_taken", i), {31'b0, bus.taken}, {31'b0, v[i].exp_taken});
      chk($sformatf("v%0d_plus4", i), bus.pc_plus4, v[i].setpc + 32'd4);
      step();
      chk($sformatf("v%0d_pc", i), bus.pc, v[i].exp_pc);
    end
    setpc(32'h20);
    bus.jal = 1; bus.imm = 32'h6;
    step();
    chk("trap_mis", {31'b0, bus.misaligned}, 32'h1);
    chk("trap_pc", bus.trap_pc, 32'h20);
    chk("trap_taken", {31'b0, bus.taken}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      bus.stall = i[0];
      step();
      chk("trap_hold_pc", bus.pc, 32'h20);
      chk("trap_hold_mis", {31'b0, bus.misaligned}, 32'h1);
    end
    bus.stall = 0; bus.jal = 0; bus.trap_ack = 1;
    step();
    chk("ack_pc", bus.pc, 32'h100);
    chk("ack_mis", {31'b0, bus.misaligned}, 32'h0);
    step();
    chk("ack_in_run_ignored", bus.pc, 32'h104);
    idle();
    bus.jalr = 1; bus.alu_result = 32'h102;
    step();
    chk("jalr_mis", {31'b0, bus.misaligned}, 32'h1);
    idle();
    bus.trap_ack = 1;
    step();
    chk("first_cycle_ack_pc", bus.pc, 32'h100);
    chk("first_cycle_ack_mis", {31'b0, bus.misaligned}, 32'h0);
    setpc(32'h40);
    bus.stall = 1; bus.branch = 1; bus.funct3 = 3'b101; bus.bge = 1; bus.imm = 32'h10;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", bus.pc, 32'h40);
      chk("stall_taken", {31'b0, bus.taken}, 32'h1);
    end
    bus.stall = 0;
    step();
    chk("stall_release_pc", bus.pc, 32'h50);
    idle();
    bus.stall = 1; bus.jal = 1; bus.imm = 32'h2;
    step();
    chk("stall_no_trap", {31'b0, bus.misaligned}, 32'h0);
    chk("stall_no_trap_pc", bus.pc, 32'h50);
    bus.stall = 0;
    step();
    chk("trap2_mis", {31'b0, bus.misaligned}, 32'h1);
    chk("trap2_pc", bus.trap_pc, 32'h50);
    idle();
    rst_n = 0;
    step();
    chk("rst_trap_pc_reg", bus.pc, 32'h0);
    chk("rst_trap_mis", {31'b0, bus.misaligned}, 32'h0);
    chk("rst_trap_trap_pc", bus.trap_pc, 32'h0);
    step();
    chk("rst_hold_pc", bus.pc, 32'h0);
    rst_n = 1;
    step();
    chk("post_rst_pc", bus.pc, 32'h4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
